// File: rtl/fsm_pkt_checker_pkg.sv
// rtl/fsm_pkt_checker_pkg.sv - shared state and error-code definitions for the packet checker
package fsm_pkt_checker_pkg;

    // One-hot state encoding; the raw vector is exported on the state/nxt_state ports.
    typedef enum logic [4:0] {
        ST_RESET  = 5'b00001,
        ST_INIT   = 5'b00010,
        ST_IDLE   = 5'b00100,
        ST_ACTIVE = 5'b01000,
        ST_ERROR  = 5'b10000
    } state_t;

    // Bit 0 flags a header mismatch, bit 1 a sequence mismatch.
    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_HDR  = 2'b01,
        ERR_SEQ  = 2'b10,
        ERR_BOTH = 2'b11
    } err_t;

endpackage

// File: rtl/fsm_pkt_checker_if.sv
// rtl/fsm_pkt_checker_if.sv - packet bus and status signals of the packet checker
//  Optional macro FSM_ERR_CNT_EN adds err_count and the CNT_WIDTH parameter.
//  master : drives bus_valid/bus_data_in, observes all checker outputs
//  slave  : the checker itself
interface fsm_pkt_checker_if #(
    parameter int BUS_SIZE  = 16,
    parameter int WORD_SIZE = 4
`ifdef FSM_ERR_CNT_EN
    ,
    parameter int CNT_WIDTH = 8
`endif
) ();
    logic                 bus_valid;
    logic [BUS_SIZE-1:0]  bus_data_in;
    logic [BUS_SIZE-1:0]  bus_data_out;
    logic                 out_valid;
    logic [4:0]           state;
    logic [4:0]           nxt_state;
    logic                 error;
    logic                 nxt_error;
    logic [1:0]           error_type;
    logic [WORD_SIZE-1:0] exp_seq;
`ifdef FSM_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] err_count;
`endif

    modport master (
        output bus_valid, bus_data_in,
        input  bus_data_out, out_valid, state, nxt_state,
        input  error, nxt_error, error_type, exp_seq
`ifdef FSM_ERR_CNT_EN
        ,
        input  err_count
`endif
    );

    modport slave (
        input  bus_valid, bus_data_in,
        output bus_data_out, out_valid, state, nxt_state,
        output error, nxt_error, error_type, exp_seq
`ifdef FSM_ERR_CNT_EN
        ,
        output err_count
`endif
    );
endinterface

// File: rtl/fsm_pkt_checker_word_check.sv
// rtl/fsm_pkt_checker_word_check.sv - combinational header/sequence word comparison
//  Ports: bus_data_in (packet), exp_seq (expected sequence) ->
//         hdr_ok, seq_ok, rx_seq (received sequence word)
module pkt_word_check #(
    parameter int                   BUS_SIZE  = 16,
    parameter int                   WORD_SIZE = 4,
    parameter logic [WORD_SIZE-1:0] HEADER    = 'hF
) (
    input  logic [BUS_SIZE-1:0]  bus_data_in,
    input  logic [WORD_SIZE-1:0] exp_seq,
    output logic                 hdr_ok,
    output logic                 seq_ok,
    output logic [WORD_SIZE-1:0] rx_seq
);
    logic [WORD_SIZE-1:0] rx_hdr;
    // Payload bits between header and sequence are forwarded but never inspected.
    logic                 unused_payload;

    assign rx_hdr         = bus_data_in[BUS_SIZE-1 -: WORD_SIZE];
    assign rx_seq         = bus_data_in[WORD_SIZE-1:0];
    assign hdr_ok         = (rx_hdr == HEADER);
    assign seq_ok         = (rx_seq == exp_seq);
    assign unused_payload = ^bus_data_in;
endmodule

// File: rtl/fsm_pkt_checker.sv
// rtl/fsm_pkt_checker.sv - packet checker FSM: header/sequence check, forward, classify, resync
//  Optional macro FSM_ERR_CNT_EN: saturating err_count of detected bad packets.
//  Ports: clk, reset (sync, active-low), bus (fsm_pkt_checker_if.slave):
//         bus_valid/bus_data_in in; bus_data_out, out_valid, state, nxt_state,
//         error, nxt_error, error_type, exp_seq (and err_count) out.
module fsm_pkt_checker
    import fsm_pkt_checker_pkg::*;
#(
    parameter int                   BUS_SIZE  = 16,
    parameter int                   WORD_SIZE = 4,
    parameter logic [WORD_SIZE-1:0] HEADER    = 'hF
`ifdef FSM_ERR_CNT_EN
    ,
    parameter int                   CNT_WIDTH = 8
`endif
) (
    input  logic               clk,
    input  logic               reset,
    fsm_pkt_checker_if.slave   bus
);
    state_t               state_q, state_d;
    logic                 error_q, error_d;
    err_t                 etype_q, etype_d;
    logic [BUS_SIZE-1:0]  data_q, data_d;
    logic                 valid_q, valid_d;
    logic [WORD_SIZE-1:0] exp_q, exp_d;
    logic                 err_event;

    logic                 hdr_ok, seq_ok;
    logic [WORD_SIZE-1:0] rx_seq;

    pkt_word_check #(
        .BUS_SIZE  (BUS_SIZE),
        .WORD_SIZE (WORD_SIZE),
        .HEADER    (HEADER)
    ) u_word_check (
        .bus_data_in (bus.bus_data_in),
        .exp_seq     (exp_q),
        .hdr_ok      (hdr_ok),
        .seq_ok      (seq_ok),
        .rx_seq      (rx_seq)
    );

    always_comb begin
        state_d   = state_q;
        error_d   = error_q;
        etype_d   = etype_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        exp_d     = exp_q;
        err_event = 1'b0;

        if (!reset) begin
            // Reset wins over everything, so the exported next values reflect it too.
            state_d = ST_RESET;
            error_d = 1'b0;
            etype_d = ERR_NONE;
            data_d  = '0;
            exp_d   = '0;
        end else begin
            unique case (state_q)
                ST_RESET: state_d = ST_INIT;
                ST_INIT:  state_d = ST_IDLE;
                ST_IDLE, ST_ACTIVE: begin
                    if (bus.bus_valid) begin
                        if (hdr_ok && seq_ok) begin
                            state_d = ST_ACTIVE;
                            data_d  = bus.bus_data_in;
                            valid_d = 1'b1;
                            exp_d   = exp_q + 1'b1;
                            error_d = 1'b0;
                            etype_d = ERR_NONE;
                        end else begin
                            state_d   = ST_ERROR;
                            data_d    = '0;
                            error_d   = 1'b1;
                            etype_d   = err_t'({~seq_ok, ~hdr_ok});
                            err_event = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        error_d = 1'b0;
                        etype_d = ERR_NONE;
                    end
                end
                ST_ERROR: begin
                    if (bus.bus_valid) begin
                        if (hdr_ok) begin
                            // Resync: adopt the received sequence instead of judging it.
                            state_d = ST_ACTIVE;
                            data_d  = bus.bus_data_in;
                            valid_d = 1'b1;
                            exp_d   = rx_seq + 1'b1;
                            error_d = 1'b0;
                            etype_d = ERR_NONE;
                        end else begin
                            data_d    = '0;
                            error_d   = 1'b1;
                            etype_d   = ERR_HDR;
                            err_event = 1'b1;
                        end
                    end else begin
                        error_d = 1'b1;
                    end
                end
                default: begin
                    // Illegal one-hot value: restart cleanly.
                    state_d = ST_RESET;
                    error_d = 1'b0;
                    etype_d = ERR_NONE;
                    data_d  = '0;
                    exp_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RESET;
            error_q <= 1'b0;
            etype_q <= ERR_NONE;
            data_q  <= '0;
            valid_q <= 1'b0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            error_q <= error_d;
            etype_q <= etype_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            exp_q   <= exp_d;
        end
    end

`ifdef FSM_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (err_event && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.err_count = cnt_q;
`endif

    assign bus.state        = state_q;
    assign bus.nxt_state    = state_d;
    assign bus.error        = error_q;
    assign bus.nxt_error    = error_d;
    assign bus.error_type   = etype_q;
    assign bus.bus_data_out = data_q;
    assign bus.out_valid    = valid_q;
    assign bus.exp_seq      = exp_q;
endmodule
